// File: rtl/cracker_pkg.sv
// Shared types and helpers for the password-candidate pipeline.
// Provides the generator FSM state type, character width and alphabet bounds.
package cracker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} gen_state_t;

  localparam int CHAR_W      = 8;
  localparam int CHARSET_MAX = 62;

  localparam logic [7:0] DIGIT_END  = 8'd10;
  localparam logic [7:0] UPPER_END  = 8'd36;
  localparam logic [7:0] DIGIT_BASE = 8'h30;
  localparam logic [7:0] UPPER_BASE = 8'h37;
  localparam logic [7:0] LOWER_BASE = 8'h3D;

  // Maps 0-9, 10-35, 36-61 onto '0'-'9', 'A'-'Z', 'a'-'z'.
  function automatic logic [7:0] idx_to_ascii(input logic [7:0] idx);
    if (idx < DIGIT_END)      return idx + DIGIT_BASE;
    else if (idx < UPPER_END) return idx + UPPER_BASE;
    else                      return idx + LOWER_BASE;
  endfunction

endpackage

// File: rtl/clk_div_edge_sync.sv
// Brings the divided clock into the clk domain as data and emits a one-cycle
// tick for every rising edge of clk_div.
module clk_div_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
  output logic tick
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_div;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/candidate_generator.sv
// Brute-force candidate source: a base-CHARSET odometer stepped by clk_div ticks,
// handed to the hash stage over valid/ready. Optional CAND_CNT_EN adds cand_cnt.
module candidate_generator #(
  parameter int LEN     = 8,
  parameter int CHARSET = 62,
  parameter int CHAR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div,
  input  logic                  start,
  input  logic                  stop,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic [LEN*CHAR_W-1:0] cand_data,
  output logic                  done
`ifdef CAND_CNT_EN
  ,
  output logic [31:0]           cand_cnt
`endif
);

  import cracker_pkg::*;

  localparam int DIG_W = $clog2(CHARSET);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(CHARSET - 1);

  typedef logic [LEN-1:0][DIG_W-1:0] odo_t;

  gen_state_t            state, state_n;
  odo_t                  odo, odo_n, odo_inc;
  logic [LEN*CHAR_W-1:0] data_n;
  logic                  valid_n, done_n, odo_last, tick, carry;

  clk_div_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .tick    (tick)
  );

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    odo_inc = odo;
    carry   = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      if (carry) begin
        if (odo[i] == DIG_MAX) begin
          odo_inc[i] = '0;
        end else begin
          odo_inc[i] = odo[i] + 1'b1;
          carry      = 1'b0;
        end
      end
    end
    odo_last = (odo == {LEN{DIG_MAX}});
  end

  always_comb begin
    state_n = state;
    odo_n   = odo;
    data_n  = cand_data;
    valid_n = cand_valid;
    done_n  = done;
    if (stop) begin
      state_n = IDLE;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = RUN;
            odo_n   = '0;
            done_n  = 1'b0;
          end
        end
        RUN: begin
          if (tick) begin
            for (int i = 0; i < LEN; i++)
              data_n[CHAR_W*i +: CHAR_W] = CHAR_W'(idx_to_ascii(8'(odo[i])));
            valid_n = 1'b1;
            state_n = WAIT;
          end
        end
        WAIT: begin
          // Ticks seen here are simply dropped; the odometer only moves on accept.
          if (cand_ready) begin
            valid_n = 1'b0;
            if (odo_last) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              odo_n   = odo_inc;
              state_n = RUN;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: the odometer and data register are plain flops, not a memory, so they
  // take the async reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      odo        <= '0;
      cand_data  <= '0;
      cand_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      odo        <= odo_n;
      cand_data  <= data_n;
      cand_valid <= valid_n;
      done       <= done_n;
    end
  end

`ifdef CAND_CNT_EN
  logic start_acc, accept;

  assign start_acc = !stop && (state == IDLE || state == DONE) && start;
  assign accept    = !stop && (state == WAIT) && cand_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cand_cnt <= '0;
    else if (start_acc)
      cand_cnt <= '0;
    else if (accept && cand_cnt != 32'hFFFF_FFFF)
      cand_cnt <= cand_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_candidate_generator.sv
// Directed bench for candidate_generator with LEN=2, CHARSET=62 and a 10:1 clk_div.
module tb_candidate_generator;

  logic        clk = 1'b0;
  logic        rst, clk_div, start, stop, cand_ready;
  logic        cand_valid, done;
  logic [15:0] cand_data;
`ifdef CAND_CNT_EN
  logic [31:0] cand_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int div_cnt  = 0;

  string cs = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";

  candidate_generator #(.LEN(2), .CHARSET(62), .CHAR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .start      (start),
    .stop       (stop),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_data  (cand_data),
    .done       (done)
`ifdef CAND_CNT_EN
    ,
    .cand_cnt   (cand_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial clk_div = 1'b1;
  always @(negedge clk) begin
    div_cnt = (div_cnt == 9) ? 0 : div_cnt + 1;
    clk_div = (div_cnt < 5);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic get_cand(input string tag, output logic [15:0] d, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!cand_valid && gap < 40);
    check({tag, "_valid"}, {31'd0, cand_valid}, 32'd1);
    d = cand_data;
  endtask

  logic [15:0] d;
  logic [15:0] exp_d;
  int          gap;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, cand_valid}, 32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_data",  {16'd0, cand_data},  32'd0);
    rst = 1'b0;

    // Reset in the middle of a handshake.
    pulse_start();
    get_cand("t1", d, gap);
    check("t1_first", {16'd0, d}, 32'h3030);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_valid", {31'd0, cand_valid}, 32'd0);
    check("t1_rst_done",  {31'd0, done},       32'd0);
    check("t1_rst_data",  {16'd0, cand_data},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t1_idle_valid", {31'd0, cand_valid}, 32'd0);

    // Free-running handshakes, one per tick.
    cand_ready = 1'b1;
    pulse_start();
    get_cand("t2a", d, gap);
    check("t2_first", {16'd0, d}, 32'h3030);
    get_cand("t2b", d, gap);
    check("t2_second", {16'd0, d}, 32'h3031);
    check("t2_gap", gap, 32'd10);

    // Back-pressure holds the candidate without skipping.
    get_cand("t3a", d, gap);
    cand_ready = 1'b0;
    check("t3_presented", {16'd0, d}, 32'h3032);
    repeat (25) @(negedge clk);
    check("t3_hold_data",  {16'd0, cand_data}, 32'h3032);
    check("t3_hold_valid", {31'd0, cand_valid}, 32'd1);
    cand_ready = 1'b1;
    get_cand("t3b", d, gap);
    check("t3_next", {16'd0, d}, 32'h3033);

    // Rest of the keyspace against the alphabet table.
    for (int k = 4; k < 3844; k++) begin
      get_cand("seq", d, gap);
      exp_d = {cs[k / 62], cs[k % 62]};
      check($sformatf("seq_%0d", k), {16'd0, d}, {16'd0, exp_d});
      case (k)
        9:  check("b_39", {16'd0, d}, 32'h3039);
        10: check("b_41", {16'd0, d}, 32'h3041);
        35: check("b_5A", {16'd0, d}, 32'h305A);
        36: check("b_61", {16'd0, d}, 32'h3061);
        61: check("b_7A", {16'd0, d}, 32'h307A);
        62: check("b_carry", {16'd0, d}, 32'h3130);
        default: ;
      endcase
    end
    check("t5_last", {16'd0, d}, 32'h7A7A);
    @(negedge clk);
    check("t5_done",  {31'd0, done},       32'd1);
    check("t5_valid", {31'd0, cand_valid}, 32'd0);
`ifdef CAND_CNT_EN
    check("t5_cnt", cand_cnt, 32'd3844);
`endif
    repeat (30) @(negedge clk);
    check("t5_done_hold",  {31'd0, done},       32'd1);
    check("t5_valid_hold", {31'd0, cand_valid}, 32'd0);
    pulse_start();
    check("t5_restart_done", {31'd0, done}, 32'd0);
`ifdef CAND_CNT_EN
    check("t5_cnt_clear", cand_cnt, 32'd0);
`endif
    get_cand("t5r", d, gap);
    check("t5_restart", {16'd0, d}, 32'h3030);

    // Stop after five accepts.
    for (int i = 1; i < 5; i++) begin
      get_cand("t6", d, gap);
      check($sformatf("t6_cand_%0d", i), {16'd0, d}, 32'h3030 + i);
    end
    @(negedge clk);
`ifdef CAND_CNT_EN
    check("t6_cnt5", cand_cnt, 32'd5);
`endif
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t6_stop_valid", {31'd0, cand_valid}, 32'd0);
    check("t6_stop_done",  {31'd0, done},       32'd0);
    repeat (30) @(negedge clk);
    check("t6_idle_valid", {31'd0, cand_valid}, 32'd0);

    // Stop beats a simultaneous start.
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_stopwins_valid", {31'd0, cand_valid}, 32'd0);
`ifdef CAND_CNT_EN
    check("t6_cnt_held", cand_cnt, 32'd5);
`endif

    // Stop aborts a pending candidate.
    cand_ready = 1'b0;
    pulse_start();
`ifdef CAND_CNT_EN
    check("t6_cnt_start_clear", cand_cnt, 32'd0);
`endif
    get_cand("t7", d, gap);
    check("t7_cand", {16'd0, d}, 32'h3030);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t7_abort_valid", {31'd0, cand_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
